// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The fetch packet carries the PC and the 32-bit instruction fetched from it.
package fetch_stage_pkg;

    localparam int          PC_W      = 64;
    localparam logic [63:0] RESET_PC  = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        REQ,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } fetch_pkt_t;

    // Sequential PC advance; wraps naturally at 2^PC_W.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus between the fetch stage (master) and the memory side (slave).
// One request in flight at a time; responses are single-cycle and never stalled.
interface fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            ireq_ack;
    logic            iresp_valid;
    logic [31:0]     iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  ireq_ack,
        input  iresp_valid,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output ireq_ack,
        output iresp_valid,
        output iresp_data
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch packet that arrived while decode stalled.
// Flush beats push, push beats pop.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  fetch_pkt_t push_pkt,
    output logic       valid,
    output fetch_pkt_t pkt
);

    logic       valid_reg;
    fetch_pkt_t pkt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= 1'b0;
            pkt_reg   <= '{pc: '0, instr: NOP_INSTR};
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (push) begin
            valid_reg <= 1'b1;
            pkt_reg   <= push_pkt;
        end else if (pop) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign pkt   = pkt_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one bus request at a time and
// hands {pc, instr} to decode through an output register backed by a skid entry.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          XLEN     = PC_W,
    parameter logic [63:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
    input  logic             clk,
    input  logic             resetn,
    fetch_stage_if.master    ibus,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             stall,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            discard_reg, discard_next;
    logic            out_valid_reg, out_valid_next;
    fetch_pkt_t      out_pkt_reg, out_pkt_next;

    logic            skid_valid;
    fetch_pkt_t      skid_pkt;
    logic            skid_push, skid_pop, skid_flush;

    logic            issue, fire, transfer, accept;
    fetch_pkt_t      resp_pkt;

    // Issue is blocked while the skid entry is occupied, so a response can
    // never arrive with nowhere to go.
    assign issue    = (state_reg == REQ) && !skid_valid;
    assign fire     = issue && ibus.ireq_ack;
    assign transfer = out_valid_reg && !stall;
    assign resp_pkt = '{pc: pc_reg, instr: ibus.iresp_data};

    assign ibus.ireq_valid = issue;
    assign ibus.ireq_addr  = pc_reg;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        discard_next   = discard_reg;
        out_valid_next = out_valid_reg;
        out_pkt_next   = out_pkt_reg;
        skid_push      = 1'b0;
        skid_pop       = 1'b0;
        skid_flush     = 1'b0;
        accept         = 1'b0;

        if (redirect_valid) begin
            // Redirect flushes everything downstream, even under stall.
            pc_next        = redirect_pc;
            out_valid_next = 1'b0;
            skid_flush     = 1'b1;
            case (state_reg)
                REQ: begin
                    if (fire) begin
                        // Old address already went out: its response is stale.
                        state_next   = WAIT;
                        discard_next = 1'b1;
                    end
                end
                WAIT: begin
                    if (ibus.iresp_valid) begin
                        state_next   = REQ;
                        discard_next = 1'b0;
                    end else begin
                        discard_next = 1'b1;
                    end
                end
                default: state_next = REQ;
            endcase
        end else begin
            case (state_reg)
                REQ: begin
                    if (fire) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (ibus.iresp_valid) begin
                        state_next = REQ;
                        if (discard_reg) begin
                            discard_next = 1'b0;
                        end else begin
                            accept  = 1'b1;
                            pc_next = next_pc(pc_reg);
                        end
                    end
                end
                default: state_next = REQ;
            endcase

            if (transfer) begin
                if (skid_valid) begin
                    out_pkt_next = skid_pkt;
                    skid_pop     = 1'b1;
                end else begin
                    out_valid_next = 1'b0;
                end
            end

            if (accept) begin
                if ((!out_valid_reg || transfer) && !skid_valid) begin
                    out_valid_next = 1'b1;
                    out_pkt_next   = resp_pkt;
                end else begin
                    skid_push = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= REQ;
            pc_reg        <= RESET_PC[XLEN-1:0];
            discard_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_pkt_reg   <= '{pc: '0, instr: NOP_INSTR};
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            discard_reg   <= discard_next;
            out_valid_reg <= out_valid_next;
            out_pkt_reg   <= out_pkt_next;
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (skid_flush),
        .push     (skid_push),
        .pop      (skid_pop),
        .push_pkt (resp_pkt),
        .valid    (skid_valid),
        .pkt      (skid_pkt)
    );

    assign out_valid = out_valid_reg;
    assign out_instr = out_pkt_reg.instr;
    assign out_pc    = out_pkt_reg.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: per-cycle bus/decode stimulus
// with hand-computed expected outputs, plus an asynchronous-reset sequence.
module tb_fetch_stage;

    localparam logic [63:0] A = 64'h8000_0000;

    typedef struct {
        logic        ack;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [63:0] rpc;
        logic        stall;
        logic        eiv;
        logic [63:0] eaddr;
        logic        eov;
        logic [63:0] epc;
        logic [31:0] einstr;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    int passed;
    int total;
    vec_t tbl[$];

    fetch_stage_if #(.XLEN(64)) ibus ();

    fetch_stage #(.XLEN(64), .RESET_PC(A)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ibus           (ibus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t v(input logic ack, input logic rv, input logic [31:0] rdata,
                               input logic redir, input logic [63:0] rpc, input logic st,
                               input logic eiv, input logic [63:0] eaddr, input logic eov,
                               input logic [63:0] epc, input logic [31:0] einstr);
        vec_t r;
        r.ack = ack; r.rv = rv; r.rdata = rdata; r.redir = redir; r.rpc = rpc; r.stall = st;
        r.eiv = eiv; r.eaddr = eaddr; r.eov = eov; r.epc = epc; r.einstr = einstr;
        return r;
    endfunction

    task automatic drive(input logic ack, input logic rv, input logic [31:0] rdata,
                         input logic redir, input logic [63:0] rpc, input logic st);
        ibus.ireq_ack   = ack;
        ibus.iresp_valid = rv;
        ibus.iresp_data = rdata;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        stall           = st;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        resetn = 1'b0;
        drive(0, 0, 32'h0, 0, 64'h0, 0);

        //        ack rv rdata         rd rpc                    st | iv addr        ov pc         instr
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   1, A,          0, 64'h0,     32'h13));
        tbl.push_back(v(0, 1, 32'h93,       0, 64'h0,            0,   0, A,          0, 64'h0,     32'h13));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   1, A+4,        1, A,         32'h93));
        tbl.push_back(v(0, 1, 32'h113,      0, 64'h0,            1,   0, A+4,        0, A,         32'h93));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            1,   1, A+8,        1, A+4,       32'h113));
        tbl.push_back(v(0, 1, 32'h193,      0, 64'h0,            1,   0, A+8,        1, A+4,       32'h113));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            1,   0, A+12,       1, A+4,       32'h113));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            1,   0, A+12,       1, A+4,       32'h113));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            1,   0, A+12,       1, A+4,       32'h113));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   0, A+12,       1, A+4,       32'h113));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   1, A+12,       1, A+8,       32'h193));
        tbl.push_back(v(0, 0, 32'h0,        1, A+64'h100,        0,   0, A+12,       0, A+8,       32'h193));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            0,   0, A+64'h100,  0, A+8,       32'h193));
        tbl.push_back(v(0, 1, 32'hDEAD0001, 0, 64'h0,            0,   0, A+64'h100,  0, A+8,       32'h193));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h100,  0, A+8,       32'h193));
        tbl.push_back(v(0, 1, 32'h213,      0, 64'h0,            0,   0, A+64'h100,  0, A+8,       32'h193));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h104,  1, A+64'h100, 32'h213));
        tbl.push_back(v(0, 1, 32'h293,      1, A+64'h200,        0,   0, A+64'h104,  0, A+64'h100, 32'h213));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h200,  0, A+64'h100, 32'h213));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h200,  0, A+64'h100, 32'h213));
        tbl.push_back(v(0, 0, 32'h0,        1, A+64'h300,        0,   1, A+64'h200,  0, A+64'h100, 32'h213));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h300,  0, A+64'h100, 32'h213));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h300,  0, A+64'h100, 32'h213));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h300,  0, A+64'h100, 32'h213));
        tbl.push_back(v(0, 1, 32'h313,      0, 64'h0,            0,   0, A+64'h300,  0, A+64'h100, 32'h213));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            1,   1, A+64'h304,  1, A+64'h300, 32'h313));
        tbl.push_back(v(0, 0, 32'h0,        1, A+64'h400,        1,   1, A+64'h304,  1, A+64'h300, 32'h313));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h400,  0, A+64'h300, 32'h313));
        tbl.push_back(v(1, 0, 32'h0,        1, A+64'h500,        0,   1, A+64'h400,  0, A+64'h300, 32'h313));
        tbl.push_back(v(0, 1, 32'h00000BAD, 0, 64'h0,            0,   0, A+64'h500,  0, A+64'h300, 32'h313));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h500,  0, A+64'h300, 32'h313));
        tbl.push_back(v(0, 1, 32'h513,      0, 64'h0,            0,   0, A+64'h500,  0, A+64'h300, 32'h313));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            0,   1, A+64'h504,  1, A+64'h500, 32'h513));
        tbl.push_back(v(0, 0, 32'h0,        1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, A+64'h504, 0, A+64'h500, 32'h513));
        tbl.push_back(v(1, 0, 32'h0,        0, 64'h0,            0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0, A+64'h500, 32'h513));
        tbl.push_back(v(0, 1, 32'h613,      0, 64'h0,            0,   0, 64'hFFFF_FFFF_FFFF_FFFC, 0, A+64'h500, 32'h513));
        tbl.push_back(v(0, 0, 32'h0,        0, 64'h0,            1,   1, 64'h0,      1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h613));

        // Reset values while resetn is held low.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_out_pc",    out_pc, 64'h0);
        chk("rst_out_instr", {32'h0, out_instr}, 64'h13);
        chk("rst_ireq_addr", ibus.ireq_addr, A);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ack, tbl[i].rv, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].stall);
            #1;
            chk($sformatf("c%0d_ireq_valid", i), {63'h0, ibus.ireq_valid}, {63'h0, tbl[i].eiv});
            chk($sformatf("c%0d_ireq_addr", i),  ibus.ireq_addr, tbl[i].eaddr);
            chk($sformatf("c%0d_out_valid", i),  {63'h0, out_valid}, {63'h0, tbl[i].eov});
            chk($sformatf("c%0d_out_pc", i),     out_pc, tbl[i].epc);
            chk($sformatf("c%0d_out_instr", i),  {32'h0, out_instr}, {32'h0, tbl[i].einstr});
            $display("vec %0d: iv=%b addr=%h ov=%b pc=%h instr=%h", i,
                     ibus.ireq_valid, ibus.ireq_addr, out_valid, out_pc, out_instr);
            @(negedge clk);
        end

        // Asynchronous reset in WAIT with a held packet, then a stale response.
        drive(1, 0, 32'h0, 0, 64'h0, 1);
        #1 chk("ar_issue", {63'h0, ibus.ireq_valid}, 64'h1);
        @(negedge clk);
        #1 chk("ar_wait_iv", {63'h0, ibus.ireq_valid}, 64'h0);
        chk("ar_wait_ov", {63'h0, out_valid}, 64'h1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_async_ov",    {63'h0, out_valid}, 64'h0);
        chk("ar_async_iv",    {63'h0, ibus.ireq_valid}, 64'h1);
        chk("ar_async_addr",  ibus.ireq_addr, A);
        chk("ar_async_instr", {32'h0, out_instr}, 64'h13);
        chk("ar_async_pc",    out_pc, 64'h0);
        drive(0, 1, 32'h0000BAD0, 0, 64'h0, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1 chk("ar_rel_iv", {63'h0, ibus.ireq_valid}, 64'h1);
        chk("ar_rel_addr", ibus.ireq_addr, A);
        @(negedge clk);
        #1 chk("ar_stale_ov", {63'h0, out_valid}, 64'h0);
        chk("ar_stale_iv", {63'h0, ibus.ireq_valid}, 64'h1);
        chk("ar_stale_addr", ibus.ireq_addr, A);
        drive(1, 0, 32'h0, 0, 64'h0, 0);
        @(negedge clk);
        #1 chk("ar_req_wait", {63'h0, ibus.ireq_valid}, 64'h0);
        drive(0, 1, 32'h713, 0, 64'h0, 0);
        @(negedge clk);
        #1 chk("ar_first_ov", {63'h0, out_valid}, 64'h1);
        chk("ar_first_pc",    out_pc, A);
        chk("ar_first_instr", {32'h0, out_instr}, 64'h713);
        chk("ar_next_addr",   ibus.ireq_addr, A+4);
        $display("reset seq: ov=%b pc=%h instr=%h next=%h", out_valid, out_pc, out_instr, ibus.ireq_addr);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the in-order RV64 pipeline; directly upstream of the decoder.
- Owns the PC and issues one 32-bit instruction request at a time on the instruction bus.
- Presents {pc, instr} to decode through a valid/stall interface with a one-entry skid buffer.
- Honours redirects from execute (branch/jump), discarding stale in-flight responses.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ireq_valid  out  1  instruction request valid.
- ireq_addr  out  XLEN  request address, equal to pc_q.
- ireq_ack  in  1  bus accepted request this cycle.
- iresp_valid  in  1  response data valid, single cycle, never back-pressured.
- iresp_data  in  32  fetched instruction.
- redirect_valid  in  1  execute redirects fetch.
- redirect_pc  in  XLEN  new PC; bits [1:0] are 00 by producer contract.
- stall  in  1  decode cannot accept this cycle.
- out_valid  out  1  fetch packet valid to decode.
- out_instr  out  32  instruction to decoder.
- out_pc  out  XLEN  PC of out_instr.

Behaviour:
- Clock and reset: one clock. resetn is asynchronous and active-low.
- Reset values: pc_q=RESET_PC; state=REQ; out_valid=0; out_instr=32'h0000_0013 (nop); out_pc=0; skid empty; discard=0.
- ireq_valid is 1 in the first cycle after resetn deasserts.
- At most one outstanding request.
- Transfer to decode occurs when out_valid && !stall.
- State REQ:
  - ireq_valid = !skid_valid; ireq_addr = pc_q.
  - ireq_valid && ireq_ack -> WAIT.
  - Otherwise stay in REQ. ireq_addr may change before ack only due to a redirect; the bus tolerates this.
- State WAIT:
  - ireq_valid=0.
  - iresp_valid && !discard && !redirect_valid -> accept the response; pc_q += 4 (mod 2^XLEN); -> REQ.
  - iresp_valid && discard -> drop the data; clear discard; -> REQ.
- Response placement:
  - Goes to the output register if it is empty or transferring this cycle.
  - Otherwise goes to the skid buffer.
  - The skid buffer is never full on arrival, because issue is blocked while it is occupied.
- Output refill: when the output transfers and the skid is valid, the skid moves to output in the same cycle and the skid empties.
- Redirect (highest priority, any state):
  - pc_q <= redirect_pc.
  - out_valid and skid_valid cleared next cycle.
  - In WAIT without iresp_valid this cycle: discard <= 1; stay in WAIT.
  - In WAIT with iresp_valid this cycle: data dropped; -> REQ.
  - In REQ with ireq_ack this cycle: the old address was issued; discard <= 1; -> WAIT.
  - In REQ without ack: stay in REQ; the new address is presented next cycle.
- Simultaneous stall and redirect: redirect wins; the packet is flushed.
- Latency: an ack in cycle N with a response in cycle N+k gives out_valid in cycle N+k+1.
- Throughput: with single-cycle bus and no stall, one instruction every 2 cycles.
- out_pc/out_instr hold stable while out_valid && stall.
- Reset asserted mid-operation: all state returns to reset values immediately.
  - A bus response arriving during or after reset, for a pre-reset request, is ignored because state is REQ.

Decomposition:
- Shared package common: fetch_state_t enum {REQ, WAIT}; fetch_pkt_t struct {pc, instr}; RESET_PC constant; NOP_INSTR constant.
- Sub-module fetch_skid_buf holds one fetch_pkt_t, with flush, push, pop and valid.

Test Plan:
1. Reset release, bus ack=1, resp 1 cycle later with 0x00000093 -> out_valid with pc 0x8000_0000, instr 0x00000093; next fetch addr 0x8000_0004.
2. Hold stall=1 for 6 cycles during streaming -> exactly one extra packet held in skid; no further ireq_valid; after release, packets pc …00 then …04 in order, none lost.
3. Redirect to 0x8000_0100 while in WAIT, response arrives 2 cycles later -> that response dropped; next ireq_addr 0x8000_0100; next out_pc 0x8000_0100.
4. Redirect in the same cycle as iresp_valid -> response dropped, out_valid=0 next cycle, next request to redirect_pc.
5. ireq_ack held low 5 cycles -> ireq_valid and ireq_addr stable; redirect during this window changes ireq_addr next cycle with no discard.
6. Assert resetn=0 mid-WAIT with out_valid=1 -> out_valid=0 asynchronously; after release, first request to 0x8000_0000; a late stale response is ignored.
